pixel_latency_ctrl: RTL

Region-level controller for the pixel latency (ToT) buffers: it owns the `MEM`-slot address space shared by all PixelLogic instances in a pixel region. It allocates a slot on each leading edge (drives `LE`/`LeAddr`), time-stamps it with the bunch-crossing counter, expires slots older than the trigger latency, and on `Trigger` reads matching slots back (drives `Read`, samples `Data`) into a valid/ready output stage.

---
 rtl/pixel_latency_ctrl.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_latency_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_latency_ctrl
//
// Purpose:
//   Region-level controller for the pixel latency (ToT) buffers. It owns the
//   MEM-slot address space shared by every PixelLogic instance in the region:
//   it allocates a slot on each leading edge, stamps the slot with the
//   bunch-crossing counter, frees slots older than the trigger latency, and on
//   Trigger reads the matching slots back into a valid/ready output stage.
//
// Parameters:
//   MEM     number of latency-buffer slots (width of LeAddr / Read)
//   BCID_W  bunch-crossing counter and timestamp width
//
// Ports:
//   Clk       in   region clock
//   Reset     in   synchronous, active-high reset
//   HitLe     in   a pixel leading edge occurred this cycle
//   Latency   in   trigger latency in cycles (1 .. 2^BCID_W-2, static)
//   Trigger   in   one-cycle trigger strobe
//   PixData   in   OR-combined pixel data for the slot selected by Read
//   LE        out  slot-clear/allocate strobe (HitLe & ~Full & ~Reset)
//   LeAddr    out  one-hot slot that the next leading edge will take
//   Read      out  one-hot read select to the pixels
//   HitValid  out  output word valid
//   HitReady  in   downstream accepts the word
//   HitData   out  captured ToT (15 = no hit)
//   HitBcid   out  timestamp of the slot that was read
//   Bcid      out  free-running bunch-crossing counter
//   Full      out  no free slot
//   Overflow  out  one-cycle pulse: a leading edge was dropped
//   OvfCount  out  dropped-hit count (0 unless PIX_LAT_OVF_CNT_EN)
//   dbg_state out  read FSM state (0 IDLE, 1 READ, 2 OUT)
//
// Build option:
//   PIX_LAT_OVF_CNT_EN  when defined, OvfCount is a saturating 8-bit count
//                       of Overflow pulses; otherwise it is tied to zero.
//
// Output handshake: a word is transferred on a clock edge where HitValid and
// HitReady are both 1; while HitValid=1 and HitReady=0 the word (HitData,
// HitBcid) is held unchanged, and HitValid never drops without a transfer.
// ---------------------------------------------------------------------------
module pixel_latency_ctrl #(
    parameter int MEM    = 8,
    parameter int BCID_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              HitLe,
    input  logic [BCID_W-1:0] Latency,
    input  logic              Trigger,
    input  logic [3:0]        PixData,
    output logic              LE,
    output logic [MEM-1:0]    LeAddr,
    output logic [MEM-1:0]    Read,
    output logic              HitValid,
    input  logic              HitReady,
    output logic [3:0]        HitData,
    output logic [BCID_W-1:0] HitBcid,
    output logic [BCID_W-1:0] Bcid,
    output logic              Full,
    output logic              Overflow,
    output logic [7:0]        OvfCount,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MEM-1:0]      busy_q, busy_d;
    logic [MEM-1:0]      pend_q, pend_d;
    logic [BCID_W-1:0]   ts_q [MEM];
    logic [BCID_W-1:0]   ts_d [MEM];
    logic [MEM-1:0]      le_addr_q, le_addr_d;
    logic [MEM-1:0]      read_q, read_d;
    logic                hit_valid_q, hit_valid_d;
    logic [3:0]          hit_data_q, hit_data_d;
    logic [BCID_W-1:0]   hit_bcid_q, hit_bcid_d;
    logic [BCID_W-1:0]   bcid_q, bcid_d;
    logic                overflow_q, overflow_d;

    logic                full;
    logic                le;
    logic [BCID_W-1:0]   trig_target;
    logic [BCID_W-1:0]   sel_ts;

    // One-hot of the lowest set bit; all-zero for an all-zero vector.
    function automatic logic [MEM-1:0] lowest_one(input logic [MEM-1:0] v);
        logic [MEM-1:0] r;
        r = '0;
        for (int i = MEM - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    assign full        = &busy_q;
    assign le          = HitLe & ~full & ~Reset;
    // A slot whose age equals Latency this cycle carries this timestamp.
    assign trig_target = bcid_q - Latency;

    // Timestamp of the slot currently being read (Read is one-hot or zero).
    always_comb begin
        sel_ts = '0;
        for (int i = 0; i < MEM; i++) begin
            if (read_q[i]) begin
                sel_ts = sel_ts | ts_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pend_d      = pend_q;
        ts_d        = ts_q;
        read_d      = read_q;
        hit_valid_d = hit_valid_q;
        hit_data_d  = hit_data_q;
        hit_bcid_d  = hit_bcid_q;
        bcid_d      = bcid_q + 1'b1;
        overflow_d  = HitLe & full;

        for (int i = 0; i < MEM; i++) begin
            // Expiry: age strictly greater than Latency. Pending slots are
            // waiting to be read and must survive until they are.
            if (busy_q[i] && !pend_q[i] && ((bcid_q - ts_q[i]) > Latency)) begin
                busy_d[i] = 1'b0;
            end
            // Trigger match: age exactly Latency. The slot in READ is
            // excluded because it is cleared on this very edge.
            if (Trigger && busy_q[i] && (ts_q[i] == trig_target) &&
                !((state_q == S_READ) && read_q[i])) begin
                pend_d[i] = 1'b1;
            end
        end

        // Allocation always targets a non-busy slot, so it never collides
        // with expiry, trigger marking or the read clear.
        if (le) begin
            for (int i = 0; i < MEM; i++) begin
                if (le_addr_q[i]) begin
                    busy_d[i] = 1'b1;
                    ts_d[i]   = bcid_q;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                // Looking at pend_d lets a trigger in an idle cycle raise
                // Read on the very next cycle.
                if (|pend_d) begin
                    read_d  = lowest_one(pend_d);
                    state_d = S_READ;
                end
            end
            S_READ: begin
                hit_data_d  = PixData;
                hit_bcid_d  = sel_ts;
                hit_valid_d = 1'b1;
                busy_d      = busy_d & ~read_q;
                pend_d      = pend_d & ~read_q;
                read_d      = '0;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (HitReady) begin
                    hit_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered from the next busy vector so LeAddr always names the lowest
    // free slot of the current busy state; a freed slot shows up here on the
    // cycle after it was released.
    assign le_addr_d = lowest_one(~busy_d);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            busy_q      <= '0;
            pend_q      <= '0;
            for (int i = 0; i < MEM; i++) begin
                ts_q[i] <= '0;
            end
            le_addr_q   <= {{(MEM-1){1'b0}}, 1'b1};
            read_q      <= '0;
            hit_valid_q <= 1'b0;
            hit_data_q  <= '0;
            hit_bcid_q  <= '0;
            bcid_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            ts_q        <= ts_d;
            le_addr_q   <= le_addr_d;
            read_q      <= read_d;
            hit_valid_q <= hit_valid_d;
            hit_data_q  <= hit_data_d;
            hit_bcid_q  <= hit_bcid_d;
            bcid_q      <= bcid_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef PIX_LAT_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Counts on the same edge that raises Overflow; sticks at 255.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (overflow_d && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign OvfCount = ovf_cnt_q;
`else
    assign OvfCount = '0;
`endif

    assign LE        = le;
    assign LeAddr    = le_addr_q;
    assign Read      = read_q;
    assign HitValid  = hit_valid_q;
    assign HitData   = hit_data_q;
    assign HitBcid   = hit_bcid_q;
    assign Bcid      = bcid_q;
    assign Full      = full;
    assign Overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule
